// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int          DEFAULT_DEPTH = 256;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  // Little-endian packing: lane k occupies bits [8k+7:8k].
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the loader, bundled as one interface.
interface imem_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into IMEM and keeps
// the CPU in reset until a complete, valid image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [15:0] words_acc;
  logic [1:0]  lane;
  logic [31:0] word_buf;
  logic [7:0]  checksum;
  logic        xfer;
  logic        start_ok;

  assign xfer     = bus.rx_valid & bus.rx_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE) | (state == ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    len_full     = {bus.rx_data, len_lo};
    bus.rx_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    cpu_hold     = 1'b1;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LEN_LO;
        done     = (state == DONE);
        err      = (state == ERR);
        cpu_hold = (state != DONE);
      end
      LEN_LO: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (xfer) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (xfer) begin
          if (len_full > 16'(DEPTH))  state_nxt = ERR;
          else if (len_full == 16'd0) state_nxt = CHK;
          else                        state_nxt = DATA;
        end
      end
      DATA: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (xfer && lane == 2'd3 && (words_acc + 16'd1) == len) state_nxt = CHK;
      end
      CHK: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (xfer) state_nxt = (bus.rx_data == checksum) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe trails the lane-3 byte by one cycle; the address and
  // word count advance on the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= BASE_ADDR;
      bus.imem_wdata <= 32'h0;
      word_cnt       <= '0;
      checksum       <= 8'h00;
      lane           <= 2'd0;
      word_buf       <= 32'h0;
      words_acc      <= 16'd0;
      len_lo         <= 8'h00;
      len            <= 16'd0;
    end else begin
      bus.imem_we <= 1'b0;
      if (bus.imem_we) begin
        bus.imem_waddr <= bus.imem_waddr + 32'd4;
        word_cnt       <= word_cnt + (ADDR_W+1)'(1);
      end
      if (start_ok) begin
        bus.imem_waddr <= BASE_ADDR;
        word_cnt       <= '0;
        checksum       <= 8'h00;
        lane           <= 2'd0;
        words_acc      <= 16'd0;
      end else if (xfer) begin
        case (state)
          LEN_LO: len_lo <= bus.rx_data;
          LEN_HI: len    <= len_full;
          DATA: begin
            checksum <= checksum ^ bus.rx_data;
            lane     <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= put_lane(word_buf, lane, bus.rx_data);
              words_acc      <= words_acc + 16'd1;
            end else begin
              word_buf <= put_lane(word_buf, lane, bus.rx_data);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled at byte/word level,
// expected IMEM writes are queued and matched by an independent monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          DEPTH     = 256;
  localparam int          ADDR_W    = 8;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            cpu_hold, busy, done, err;
  logic [ADDR_W:0] word_cnt;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  logic [7:0] frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual addr=%h data=%h expected none",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", bus.imem_waddr, w.addr);
        check("write_data", bus.imem_wdata, w.data);
      end
    end
  end

  task automatic buildFrame(input int n, input bit bad_chk);
    logic [7:0]  chk;
    logic [31:0] w;
    frame = {};
    chk   = 8'h00;
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 3) == 0) ? NOP_WORD : $urandom;
        for (int k = 0; k < 4; k++) begin
          frame.push_back(w[8*k +: 8]);
          chk = chk ^ w[8*k +: 8];
        end
      end
      frame.push_back(bad_chk ? (chk ^ 8'h01) : chk);
    end
  endtask

  // Reference model: interpret the frame bytes and queue the writes it implies.
  task automatic modelFrame(output bit m_done, output bit m_err, output int m_cnt);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    wr_t         e;
    n = int'(frame[0]) + 256 * int'(frame[1]);
    x = 8'h00;
    m_cnt = 0;
    if (n > DEPTH) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
      x = x ^ frame[2+4*i] ^ frame[2+4*i+1] ^ frame[2+4*i+2] ^ frame[2+4*i+3];
      e.addr = BASE_ADDR + 32'(4 * i);
      e.data = w;
      exp_q.push_back(e);
    end
    m_cnt  = n;
    m_done = (frame[2+4*n] == x);
    m_err  = !m_done;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: random gaps, 2: valid toggling with a stray start.
  task automatic applyStimulus(input int mode, input int limit);
    int gap;
    int waited;
    for (int i = 0; i < limit && i < frame.size(); i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 3)) : 1;
      for (int g = 0; g < gap; g++) begin
        bus.rx_valid = 1'b0;
        if (mode == 2 && i == 6 && g == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      bus.rx_data  = frame[i];
      bus.rx_valid = 1'b1;
      waited = 0;
      while (bus.rx_ready !== 1'b1 && waited < 64) begin
        @(negedge clk);
        waited++;
      end
      if (bus.rx_ready !== 1'b1) begin
        bus.rx_valid = 1'b0;
        check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        return;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input bit e_done, input bit e_err, input int e_cnt);
    repeat (3) @(negedge clk);
    check({tag, "_done"},     32'(done),        32'(e_done));
    check({tag, "_err"},      32'(err),         32'(e_err));
    check({tag, "_cpu_hold"}, 32'(cpu_hold),    32'(!e_done));
    check({tag, "_busy"},     32'(busy),        32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt),    32'(e_cnt));
    check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
    exp_q = {};
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_we"},       32'(bus.imem_we),  32'd0);
    check({tag, "_waddr"},    bus.imem_waddr,    BASE_ADDR);
    check({tag, "_wdata"},    bus.imem_wdata,    32'h0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_err"},      32'(err),          32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt),     32'd0);
  endtask

  task automatic loadCase1(input logic [7:0] chk);
    frame = {8'h02, 8'h00, 8'h93, 8'h00, 8'h70, 8'h3E, 8'h13, 8'h01, 8'h90, 8'h30, chk};
    exp_q.push_back('{addr: BASE_ADDR,         data: 32'h3E70_0093});
    exp_q.push_back('{addr: BASE_ADDR + 32'd4, data: 32'h3090_0113});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit m_done, m_err;
    int m_cnt, n;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Known-good two-word image.
    pulseStart();
    check("load_busy",     32'(busy),         32'd1);
    check("load_rx_ready", 32'(bus.rx_ready), 32'd1);
    loadCase1(8'h6F);
    applyStimulus(0, frame.size());
    checkOutput("case1", 1'b1, 1'b0, 2);

    // Same image, wrong checksum.
    pulseStart();
    loadCase1(8'h6E);
    applyStimulus(0, frame.size());
    checkOutput("case2", 1'b0, 1'b1, 2);

    // Length 257 exceeds DEPTH.
    pulseStart();
    frame = {8'h01, 8'h01};
    applyStimulus(0, frame.size());
    checkOutput("case3", 1'b0, 1'b1, 0);

    // Empty image.
    pulseStart();
    frame = {8'h00, 8'h00, 8'h00};
    applyStimulus(0, frame.size());
    checkOutput("case4", 1'b1, 1'b0, 0);

    // Toggling valid with a start pulse mid-load.
    pulseStart();
    loadCase1(8'h6F);
    applyStimulus(2, frame.size());
    checkOutput("case5", 1'b1, 1'b0, 2);

    // Reset after five data bytes, then a clean reload.
    pulseStart();
    loadCase1(8'h6F);
    void'(exp_q.pop_back());
    applyStimulus(0, 7);
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    exp_q = {};
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulseStart();
    loadCase1(8'h6F);
    applyStimulus(0, frame.size());
    checkOutput("case6", 1'b1, 1'b0, 2);

    // Full-depth image.
    pulseStart();
    buildFrame(DEPTH, 1'b0);
    modelFrame(m_done, m_err, m_cnt);
    applyStimulus(0, frame.size());
    checkOutput("full", m_done, m_err, m_cnt);

    // Randomized frames.
    for (int t = 0; t < 10; t++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, DEPTH + 40))
                                       : int'($urandom_range(0, 9));
      pulseStart();
      buildFrame(n, ($urandom_range(0, 2) == 0));
      modelFrame(m_done, m_err, m_cnt);
      applyStimulus(1, frame.size());
      checkOutput("random", m_done, m_err, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
